// File: rtl/dnn_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnn_accel_pkg
// Description : Shared types for the accelerator memory fabric. Holds the
//               requester-ID encoding used by the SDRAM arbiter and its tag
//               FIFO, plus a helper that names the opposite requester.
// Revision    : 1.0 - initial release
// ============================================================================
package dnn_accel_pkg;

    typedef enum logic {
        ID_S0 = 1'b0,
        ID_S1 = 1'b1
    } req_id_t;

    function automatic req_id_t other_id(input req_id_t id);
        return (id == ID_S0) ? ID_S1 : ID_S0;
    endfunction

endpackage : dnn_accel_pkg
`default_nettype wire

// File: rtl/sdram_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tag_fifo
// Description : DEPTH-entry FIFO of 1-bit requester tags. Records which
//               requester owns each outstanding read so returns can be
//               steered in command order.
// Ports       : clk, rst_n        clock / async active-low reset
//               push, din         enqueue a tag
//               pop, dout         dequeue the head tag (dout = head)
//               full, empty       occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DEPTH-1:0]   mem_q,    mem_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;

    logic w_push_ok;
    logic w_pop_ok;

    assign full  = (count_q == c_CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed only when the head leaves in the
    // same cycle; a pop of an empty FIFO is ignored so the count never wraps.
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = din;
            // DEPTH is a power of two, so natural overflow wraps the pointer.
            wr_ptr_d        = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : tag_fifo
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Two-requester round-robin Avalon-MM arbiter in front of a
//               pipelined SDRAM controller. Read ownership is tracked in a
//               tag FIFO so in-order returns are steered to the right port.
// Ports       : clk, rst_n                    clock / async active-low reset
//               sN_address/read/write/writedata  requester N command
//               sN_waitrequest                 requester N not accepted
//               sN_readdata/readdatavalid      requester N read return
//               m_address/read/write/writedata command to the controller
//               m_waitrequest                  controller stall
//               m_readdata/readdatavalid       in-order read return
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import dnn_accel_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid
);

    req_id_t ptr_q,     ptr_d;
    logic    hold_q,    hold_d;
    req_id_t hold_id_q, hold_id_d;

    logic    w_fifo_full, w_fifo_empty, w_fifo_dout;
    logic    w_pop, w_room;
    logic    w_elig0, w_elig1;
    logic    w_sel_valid, w_active, w_accept;
    req_id_t w_sel_id;
    logic    w_sel_write;

    // A return pops the head only when a tag exists; stray returns are dropped.
    assign w_pop  = m_readdatavalid & ~w_fifo_empty;
    // A read may issue into a full FIFO when the head pops in the same cycle.
    assign w_room = ~w_fifo_full | w_pop;

    // A read blocked on tag space is not eligible, so a write from the other
    // requester can use the bus instead of idling behind it.
    assign w_elig0 = (s0_read | s0_write) & (s0_write | w_room);
    assign w_elig1 = (s1_read | s1_write) & (s1_write | w_room);

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = ID_S0;
        if (hold_q) begin
            // Stalled by the controller: keep presenting the same command.
            w_sel_id    = hold_id_q;
            w_sel_valid = (hold_id_q == ID_S0) ? w_elig0 : w_elig1;
        end else if (w_elig0 && w_elig1) begin
            w_sel_valid = 1'b1;
            w_sel_id    = ptr_q;
        end else if (w_elig0) begin
            w_sel_valid = 1'b1;
            w_sel_id    = ID_S0;
        end else if (w_elig1) begin
            w_sel_valid = 1'b1;
            w_sel_id    = ID_S1;
        end
    end

    // Gating with rst_n keeps the command bus quiet throughout reset.
    assign w_active    = w_sel_valid & rst_n;
    assign w_accept    = w_active & ~m_waitrequest;
    assign w_sel_write = (w_sel_id == ID_S0) ? s0_write : s1_write;

    assign m_write     = w_active & w_sel_write;
    assign m_read      = w_active & ~w_sel_write;
    assign m_address   = (w_sel_id == ID_S0) ? s0_address   : s1_address;
    assign m_writedata = (w_sel_id == ID_S0) ? s0_writedata : s1_writedata;

    assign s0_waitrequest = ~(w_accept && (w_sel_id == ID_S0));
    assign s1_waitrequest = ~(w_accept && (w_sel_id == ID_S1));

    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = w_pop & (w_fifo_dout == ID_S0);
    assign s1_readdatavalid = w_pop & (w_fifo_dout == ID_S1);

    always_comb begin
        ptr_d     = w_accept ? other_id(w_sel_id) : ptr_q;
        hold_d    = w_active & m_waitrequest;
        hold_id_d = (w_active && m_waitrequest) ? w_sel_id : hold_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= ID_S0;
            hold_q    <= 1'b0;
            hold_id_q <= ID_S0;
        end else begin
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            hold_id_q <= hold_id_d;
        end
    end

    tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept & m_read),
        .pop   (w_pop),
        .din   (w_sel_id),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

endmodule : sdram_arbiter
`default_nettype wire

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Parameters
REQ-001 ADDR_W, default 32, byte-address width on all ports, SHALL apply to every address port.
REQ-002 DATA_W, default 32, data width on all ports, SHALL apply to every data port.
REQ-003 MAX_OUT, default 8 (power of two), maximum outstanding reads, SHALL set the tag-FIFO depth.

Interface
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 sN_address/sN_read/sN_write/sN_writedata (N=0,1)  in  ADDR_W/1/1/DATA_W  requester N Avalon-MM slave request.
REQ-007 sN_waitrequest  out  1  requester N command not accepted this cycle.
REQ-008 sN_readdata/sN_readdatavalid  out  DATA_W/1  requester N read return.
REQ-009 m_address/m_read/m_write/m_writedata  out  ADDR_W/1/1/DATA_W  command to the SDRAM controller.
REQ-010 m_waitrequest  in  1  SDRAM controller stall.
REQ-011 m_readdata/m_readdatavalid  in  DATA_W/1  pipelined read return, in command order.

Function
REQ-012 Requester N SHALL be pending when sN_read or sN_write is high; asserting both SHALL be treated as a write.
REQ-013 Each cycle the arbiter SHALL select at most one pending requester and drive its command onto m_*; m_read and m_write SHALL be low when none is selected.
REQ-014 Selection SHALL be round-robin: a 1-bit pointer names the preferred requester; when both are pending the preferred one wins; when one is pending it wins.
REQ-015 A command SHALL be accepted when selected, m_waitrequest is low, and, for a read, the tag FIFO is not full.
REQ-016 On acceptance the pointer SHALL move to the other requester on the next edge; otherwise the pointer SHALL hold.
REQ-017 sN_waitrequest SHALL be low only in the cycle requester N's command is accepted; it SHALL be high while N is pending and not accepted, and it is a don't-care while N is idle.
REQ-018 Once selected and stalled, the selection SHALL hold; the arbiter SHALL not switch requesters until the command is accepted.
REQ-019 An accepted read SHALL push its requester ID into a MAX_OUT-deep tag FIFO.
REQ-020 On m_readdatavalid the FIFO head SHALL be popped, and m_readdata SHALL be forwarded combinationally to the requester named by the head with sN_readdatavalid asserted; the other requester's readdatavalid SHALL stay low.
REQ-021 When the FIFO is full, a selected read SHALL be stalled; a selected write SHALL still be accepted.
REQ-022 A push and a pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full.
REQ-023 The FIFO read and write pointers SHALL wrap modulo MAX_OUT.
REQ-024 m_readdatavalid arriving with the FIFO empty is a protocol error; it SHALL be dropped, and the occupancy count SHALL not underflow.
REQ-025 sN_readdata SHALL equal m_readdata at all times; only the valid strobes are steered.

Reset
REQ-026 While rst_n is low: pointer = 0, FIFO count, read pointer and write pointer = 0, selection hold cleared, m_read = m_write = 0, s0/s1_readdatavalid = 0.
REQ-027 Reset asserted mid-transaction SHALL discard all outstanding tags; read data returned after reset releases SHALL be dropped per REQ-024.

Structure
REQ-028 The requester-ID type and the encodings ID_S0 = 0 and ID_S1 = 1 SHALL live in the shared package dnn_accel_pkg.
REQ-029 The tag FIFO SHALL be a separate sub-module, tag_fifo (push, pop, din, dout, full, empty), parameterised by depth.

Verification
REQ-030 s0 reads 0x100 and s1 reads 0x200 in the same cycle, pointer = 0 -> s0 is accepted first, then s1; returns 0xAAAA then 0xBBBB arrive on s0 then s1 respectively.
REQ-031 m_waitrequest is high for 3 cycles while s1 writes 0x55 to 0x40 and s0 is also pending -> m_* holds the s1 write for all 3 cycles, s1_waitrequest falls in cycle 4, and s0 is granted in cycle 5.
REQ-032 s0 issues 8 reads with no return -> the 9th read stalls while an s1 write to 0x80 is accepted; one m_readdatavalid then lets the 9th read be accepted in the same cycle as the pop.
REQ-033 Both requesters stream reads continuously for 64 cycles, m_waitrequest low, latency 4 -> grants alternate, each requester gets 32 returns in issue order, and no readdatavalid is misrouted.
REQ-034 rst_n is pulsed low with 3 reads outstanding -> the FIFO count is 0 after reset, the 3 late m_readdatavalid pulses assert neither sN_readdatavalid, and the next read from s1 returns correctly.
